seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 18 +
 rtl/seg_scan_ctrl_if.sv | 32 +++
 rtl/seg_scan_timer.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared constants and state encoding for the segment scanner
package seg_scan_ctrl_pkg;

  localparam int DIGIT_W = 5;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Anything outside 0..9 is shown as blank.
  function automatic logic [DIGIT_W-1:0] sanitize_code(input logic [DIGIT_W-1:0] code);
    return (code <= 5'd9) ? code : BLANK_CODE;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - host/display bundle and slot-timer control bus
interface seg_scan_ctrl_if
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                          enable;
  logic                          load;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]         dp;
  logic                          lz_sup;
  logic [DIGIT_W-1:0]            digit;
  logic                          decimal;
  logic [NUM_DIGITS-1:0]         anode;
  logic                          frame_done;

  modport master (output enable, load, digits, dp, lz_sup,
                  input  digit, decimal, anode, frame_done);
  modport slave  (input  enable, load, digits, dp, lz_sup,
                  output digit, decimal, anode, frame_done);
endinterface

interface seg_scan_tmr_if #(
  parameter int CNT_W = 4
);
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             done;

  modport master (output load, load_val, input done);
  modport slave  (input load, load_val, output done);
endinterface

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - loadable down-counter; done while the count sits at zero
module seg_scan_timer #(
  parameter int CNT_W = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  seg_scan_tmr_if.slave tmr
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loading N-1 on entry makes done fire in the Nth cycle of the interval.
  always_comb begin
    cnt_d = cnt_q;
    if (tmr.load) begin
      cnt_d = tmr.load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmr.done = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with shadow buffer and dead time
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DRIVE_CYC  = 1000,
  parameter int DEAD_CYC   = 16,
  parameter int DEC_LAT    = 2
) (
  input  logic                          clkIn,
  input  logic                          rstNIn,
  input  logic                          enableIn,
  input  logic                          loadIn,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digitsIn,
  input  logic [NUM_DIGITS-1:0]         dpIn,
  input  logic                          lzSupIn,
  output logic [DIGIT_W-1:0]            digitOut,
  output logic                          decimalOut,
  output logic [NUM_DIGITS-1:0]         anodeOut,
  output logic                          frameDoneOut
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CYC = (DRIVE_CYC > DEAD_CYC) ? DRIVE_CYC : DEAD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LD = CNT_W'(DRIVE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_vec_t;

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pend_q, pend_d;
  digit_vec_t            shd_dig_q, shd_dig_d;
  digit_vec_t            act_dig_q, act_dig_d;
  digit_vec_t            disp_dig;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic                  shd_lz_q, shd_lz_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic                  apply;
  logic                  frame_done;
  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val;
  logic                  lead;
  logic [NUM_DIGITS-1:0] anode_raw;
  logic                  decimal_raw;

  seg_scan_tmr_if #(.CNT_W(CNT_W)) tmr_bus ();

  assign tmr_bus.load     = tmr_load;
  assign tmr_bus.load_val = tmr_val;

  seg_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i  (clkIn),
    .rst_ni (rstNIn),
    .tmr    (tmr_bus)
  );

  // Resolve the shadow set into display codes once, at apply time.
  always_comb begin
    lead     = shd_lz_q;
    disp_dig = shd_dig_q;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (lead && (i != 0) && (shd_dig_q[i] == '0)) begin
        disp_dig[i] = BLANK_CODE;
      end else begin
        disp_dig[i] = sanitize_code(shd_dig_q[i]);
      end
      if (shd_dig_q[i] != '0) begin
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    shd_dig_d  = shd_dig_q;
    shd_dp_d   = shd_dp_q;
    shd_lz_d   = shd_lz_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    digit_d    = BLANK_CODE;
    apply      = 1'b0;
    frame_done = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = DEAD_LD;

    case (state_q)
      ST_IDLE: begin
        state_d  = ST_DEAD;
        idx_d    = '0;
        tmr_load = 1'b1;
        apply    = pend_q;
      end
      ST_DEAD: begin
        if (tmr_bus.done) begin
          state_d  = ST_DRIVE;
          tmr_load = 1'b1;
          tmr_val  = DRIVE_LD;
        end
      end
      ST_DRIVE: begin
        if (tmr_bus.done) begin
          state_d  = ST_DEAD;
          tmr_load = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            frame_done = 1'b1;
            apply      = pend_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enableIn) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      tmr_load   = 1'b0;
      apply      = 1'b0;
      frame_done = 1'b0;
    end

    if (state_d == ST_DRIVE) begin
      digit_d = act_dig_q[idx_q];
    end

    // Apply consumes the old shadow; a load in the same cycle stays pending.
    if (apply) begin
      act_dig_d = disp_dig;
      act_dp_d  = shd_dp_q;
      pend_d    = 1'b0;
    end
    if (loadIn) begin
      shd_dig_d = digitsIn;
      shd_dp_d  = dpIn;
      shd_lz_d  = lzSupIn;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      shd_dig_q <= {NUM_DIGITS{BLANK_CODE}};
      shd_dp_q  <= '0;
      shd_lz_q  <= 1'b0;
      act_dig_q <= {NUM_DIGITS{BLANK_CODE}};
      act_dp_q  <= '0;
      digit_q   <= BLANK_CODE;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      shd_lz_q  <= shd_lz_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      digit_q   <= digit_d;
    end
  end

  always_comb begin
    anode_raw   = '1;
    decimal_raw = 1'b1;
    if (state_q == ST_DRIVE) begin
      anode_raw[idx_q] = 1'b0;
      decimal_raw      = ~act_dp_q[idx_q];
    end
  end

  generate
    if (DEC_LAT == 0) begin : g_no_delay
      assign anodeOut   = anode_raw;
      assign decimalOut = decimal_raw;
    end else begin : g_delay
      logic [DEC_LAT-1:0][NUM_DIGITS-1:0] anode_pipe_q;
      logic [DEC_LAT-1:0]                 decimal_pipe_q;

      // Disable flushes every stage so no anode stays lit after enable drops.
      always_ff @(posedge clkIn) begin
        if (!rstNIn || !enableIn) begin
          anode_pipe_q   <= '1;
          decimal_pipe_q <= '1;
        end else begin
          anode_pipe_q[0]   <= anode_raw;
          decimal_pipe_q[0] <= decimal_raw;
          for (int k = 1; k < DEC_LAT; k++) begin
            anode_pipe_q[k]   <= anode_pipe_q[k-1];
            decimal_pipe_q[k] <= decimal_pipe_q[k-1];
          end
        end
      end

      assign anodeOut   = anode_pipe_q[DEC_LAT-1];
      assign decimalOut = decimal_pipe_q[DEC_LAT-1];
    end
  endgenerate

  assign digitOut     = digit_q;
  assign frameDoneOut = frame_done;

endmodule
